// File: rtl/loader_pkg.sv
// loader_pkg
// Shared types and constants for the RAM program loader.
//   state_t           : loader FSM states
//   BYTE_W / WORD_W   : host byte width and RAM word width
//   SYNC_BYTE_DEFAULT : default frame header byte
package loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    STROBE,
    GAP,
    CHK,
    FINISH
  } state_t;

endpackage

// File: rtl/loader_strobe_timer.sv
// loader_strobe_timer
// Loadable down-counter timing the STROBE and GAP phases of each RAM write.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : phase length minus one
//   expired    : counter is at zero, i.e. this is the last cycle of the phase
module loader_strobe_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/program_loader.sv
// program_loader
// Receives a framed load command from a host byte stream and writes the
// payload into the RAM through its external programming port, holding the
// CPU in reset for the duration of the load.
// Frame: SYNC_BYTE, count[15:8], count[7:0], count words (high byte first).
// Optional build macro LOADER_CHECKSUM_EN: a trailing byte carrying the
// modulo-256 sum of all data bytes is checked after the last word.
// Ports:
//   clk, rst            : clock (shared with RAM), synchronous active-high reset
//   in_data/in_valid    : host byte stream
//   in_ready            : loader accepts a byte this cycle
//   pgm, pgm_addr,
//   pgm_data, pg_wr     : RAM programming port (pg_wr is a level strobe)
//   cpu_rst             : CPU hold-in-reset, mirrors pgm
//   busy                : frame in progress
//   done / err          : one-cycle completion / failure pulses
module program_loader
  import loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR     = 16'h0000,
  parameter int                MAX_WORDS     = 256,
  parameter int                STROBE_CYCLES = 4,
  parameter int                GAP_CYCLES    = 4,
  parameter logic [BYTE_W-1:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pgm,
  output logic [WORD_W-1:0] pgm_addr,
  output logic [WORD_W-1:0] pgm_data,
  output logic              pg_wr,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int TW = $clog2(((STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES) + 1);
  localparam logic [WORD_W:0] MAX_LIMIT = (WORD_W+1)'(MAX_WORDS);

  state_t            state, next_state;
  logic              hs;
  logic [BYTE_W-1:0] cnt_hi;
  logic [WORD_W-1:0] word_total;
  logic [WORD_W-1:0] word_cnt;
  logic [WORD_W-1:0] count;
  logic              count_too_big;
  logic              last_word;
  logic              fail;
  logic              timer_load;
  logic [TW-1:0]     timer_val;
  logic              timer_done;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] sum;
`endif

  assign hs            = in_valid && in_ready;
  assign count         = {cnt_hi, in_data};
  assign count_too_big = {1'b0, count} > MAX_LIMIT;
  assign last_word     = (word_cnt + 16'd1) == word_total;

  // The timer is reloaded on entry to each phase; the phase ends in the
  // cycle where it reads zero, giving exactly N cycles per phase.
  assign timer_load = (state == DATA_LO && hs) || (state == STROBE && timer_done);
  assign timer_val  = (state == STROBE) ? TW'(GAP_CYCLES - 1) : TW'(STROBE_CYCLES - 1);

  loader_strobe_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(timer_val),
    .expired (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Every frame outcome (empty, oversize, complete, bad checksum) funnels
  // through FINISH so done/err come from one place and can never coincide.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (hs && in_data == SYNC_BYTE) next_state = CNT_HI;
      CNT_HI:  if (hs) next_state = CNT_LO;
      CNT_LO:  if (hs) next_state = (count == '0 || count_too_big) ? FINISH : DATA_HI;
      DATA_HI: if (hs) next_state = DATA_LO;
      DATA_LO: if (hs) next_state = STROBE;
      STROBE:  if (timer_done) next_state = GAP;
      GAP: begin
        if (timer_done) begin
`ifdef LOADER_CHECKSUM_EN
          next_state = last_word ? CHK : DATA_HI;
`else
          next_state = last_word ? FINISH : DATA_HI;
`endif
        end
      end
      CHK:     if (hs) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // pgm spans the whole payload phase and drops in FINISH, after the final
  // GAP, so the RAM's delayed edge detect always lands while pgm is high.
  always_comb begin
    in_ready = 1'b0;
    pgm      = 1'b0;
    pg_wr    = 1'b0;
    busy     = (state != IDLE);
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE, CNT_HI, CNT_LO: in_ready = 1'b1;
      DATA_HI, DATA_LO: begin
        in_ready = 1'b1;
        pgm      = 1'b1;
      end
      STROBE: begin
        pgm   = 1'b1;
        pg_wr = 1'b1;
      end
      GAP: pgm = 1'b1;
      CHK: begin
`ifdef LOADER_CHECKSUM_EN
        in_ready = 1'b1;
`endif
        pgm = 1'b1;
      end
      FINISH: begin
        done = !fail;
        err  = fail;
      end
      default: ;
    endcase
    cpu_rst = pgm;
  end

  // Frame datapath: count capture, word assembly, address stepping and the
  // failure flag that selects done or err in FINISH.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hi     <= '0;
      word_total <= '0;
      word_cnt   <= '0;
      pgm_addr   <= BASE_ADDR;
      pgm_data   <= '0;
      fail       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          fail     <= 1'b0;
          word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
          sum      <= '0;
`endif
        end
        CNT_HI: if (hs) cnt_hi <= in_data;
        CNT_LO: begin
          if (hs) begin
            word_total <= count;
            if (count_too_big)    fail     <= 1'b1;
            else if (count != '0) pgm_addr <= BASE_ADDR;
          end
        end
        DATA_HI: begin
          if (hs) begin
            pgm_data[15:8] <= in_data;
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + in_data;
`endif
          end
        end
        DATA_LO: begin
          if (hs) begin
            pgm_data[7:0] <= in_data;
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + in_data;
`endif
          end
        end
        GAP: begin
          if (timer_done) begin
            word_cnt <= word_cnt + 16'd1;
            if (!last_word) pgm_addr <= pgm_addr + 16'd1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (hs && in_data != sum) fail <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule
